// File: rtl/lstm_cell_seq_pkg.sv
// Shared types and fixed-point helpers for the sequential LSTM cell.
// Helpers work on 32-bit signed values; callers pass the data width and fraction bits.
package lstm_pkg;

   typedef enum logic [3:0] {
      IDLE, G0, G1, G2, G3, G4, G5, G6, G7, C0, C1, H0, DONE
   } state_t;

   localparam logic [1:0] GATE_I = 2'd0;
   localparam logic [1:0] GATE_F = 2'd1;
   localparam logic [1:0] GATE_G = 2'd2;
   localparam logic [1:0] GATE_O = 2'd3;

   function automatic logic signed [31:0] sat_dw(input logic signed [31:0] v, input int dw);
      logic signed [31:0] hi, lo;
      hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (dw - 1));
      if (v > hi) return hi;
      else if (v < lo) return lo;
      else return v;
   endfunction

   function automatic logic sat_hit(input logic signed [31:0] v, input int dw);
      logic signed [31:0] hi, lo;
      hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (dw - 1));
      return (v > hi) || (v < lo);
   endfunction

   // Hard sigmoid: slope 1/4 around 0.5, clamped to [0, 1.0].
   function automatic logic signed [31:0] hsig(input logic signed [31:0] p, input int frac);
      logic signed [31:0] t, one;
      one = 32'sd1 <<< frac;
      t   = (p >>> 2) + (32'sd1 <<< (frac - 1));
      if (t < 32'sd0) return 32'sd0;
      else if (t > one) return one;
      else return t;
   endfunction

   function automatic logic signed [31:0] htanh(input logic signed [31:0] p, input int frac);
      logic signed [31:0] one;
      one = 32'sd1 <<< frac;
      if (p > one) return one;
      else if (p < -one) return -one;
      else return p;
   endfunction

endpackage

// File: rtl/lstm_cell_seq_if.sv
// Sample-in / result-out bundle of the LSTM cell, plus a read-only view of the FSM state.
// Handshake: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
interface lstm_cell_seq_if import lstm_pkg::*; #(parameter int DW = 8);
   logic                 in_valid;
   logic                 in_ready;
   logic signed [DW-1:0] x_in;
   logic [4*DW-1:0]      w_x;
   logic [4*DW-1:0]      w_h;
   logic [4*DW-1:0]      bias;
   logic                 clear_state;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [DW-1:0] h_out;
   logic signed [DW-1:0] c_out;
   logic                 ovf;
   state_t               dbg_state;

   modport master (
      output in_valid, x_in, w_x, w_h, bias, clear_state, out_ready,
      input  in_ready, out_valid, h_out, c_out, ovf, dbg_state
   );

   modport slave (
      input  in_valid, x_in, w_x, w_h, bias, clear_state, out_ready,
      output in_ready, out_valid, h_out, c_out, ovf, dbg_state
   );
endinterface

// File: rtl/lstm_cell_seq_act.sv
// Gate activation: hard tanh when tanh_i is set, hard sigmoid otherwise.
// One instance serves all four gates because gates are finished one per cycle.
module lstm_act import lstm_pkg::*; #(
   parameter int DW   = 8,
   parameter int FRAC = 4
) (
   input  logic signed [DW-1:0] p_i,
   input  logic                 tanh_i,
   output logic signed [DW-1:0] y_o
);

   always_comb begin
      if (tanh_i) y_o = DW'(htanh(32'(p_i), FRAC));
      else        y_o = DW'(hsig(32'(p_i), FRAC));
   end

endmodule

// File: rtl/lstm_cell_seq.sv
// Time-multiplexed fixed-point LSTM cell: one shared multiplier walks the gates, then c and h.
// Owns the recurrent c/h state; one step per accepted sample, result held until taken.
module lstm_cell_seq import lstm_pkg::*; #(
   parameter int DW    = 8,
   parameter int FRAC  = 4,
   parameter int ACC_W = 2*DW + 4
) (
   input logic           clk,
   input logic           rst_n,
   lstm_cell_seq_if.slave bus
);

   state_t               state_q;
   logic signed [DW-1:0] x_q, c_q, h_q, cnew_q, h_out_q, c_out_q;
   logic signed [DW-1:0] gate_q [4];
   logic signed [ACC_W-1:0] acc_q;
   logic                 ovf_q, out_valid_q, in_ready_q;

   logic [1:0]           k;
   logic signed [DW-1:0] wx_k, wh_k, b_k;
   logic signed [DW-1:0] mul_a, mul_b;
   logic signed [2*DW-1:0] prod;
   logic signed [ACC_W-1:0] acc_load_d, acc_sum_d, sat_src, sat_shift;
   logic signed [DW-1:0] sat_v, act_y;
   logic                 sat_flag, act_tanh;

   always_comb begin
      case (state_q)
         G0, G1:  k = GATE_I;
         G2, G3:  k = GATE_F;
         G4, G5:  k = GATE_G;
         G6, G7:  k = GATE_O;
         default: k = GATE_I;
      endcase
      wx_k = bus.w_x[int'(k)*DW +: DW];
      wh_k = bus.w_h[int'(k)*DW +: DW];
      b_k  = bus.bias[int'(k)*DW +: DW];
   end

   // Operand routing for the single multiplier, one product per state.
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      case (state_q)
         G0, G2, G4, G6: begin mul_a = x_q;             mul_b = wx_k; end
         G1, G3, G5, G7: begin mul_a = h_q;             mul_b = wh_k; end
         C0:             begin mul_a = gate_q[GATE_F];  mul_b = c_q;  end
         C1:             begin mul_a = gate_q[GATE_I];  mul_b = gate_q[GATE_G]; end
         H0:             begin mul_a = gate_q[GATE_O];  mul_b = DW'(htanh(32'(cnew_q), FRAC)); end
         default: ;
      endcase
   end

   always_comb begin
      prod       = (2*DW)'(mul_a) * (2*DW)'(mul_b);
      acc_load_d = (ACC_W'(b_k) <<< FRAC) + ACC_W'(prod);
      acc_sum_d  = acc_q + ACC_W'(prod);
      sat_src    = (state_q == H0) ? ACC_W'(prod) : acc_sum_d;
      sat_shift  = sat_src >>> FRAC;
      sat_v      = DW'(sat_dw(32'(sat_shift), DW));
      sat_flag   = sat_hit(32'(sat_shift), DW);
      act_tanh   = (k == GATE_G);
   end

   lstm_act #(.DW(DW), .FRAC(FRAC)) u_act (
      .p_i    (sat_v),
      .tanh_i (act_tanh),
      .y_o    (act_y)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         x_q         <= '0;
         c_q         <= '0;
         h_q         <= '0;
         cnew_q      <= '0;
         h_out_q     <= '0;
         c_out_q     <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
         for (int g = 0; g < 4; g++) gate_q[g] <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               in_ready_q <= 1'b1;
               // Clearing and accepting on the same edge runs the step from zero state.
               if (bus.clear_state) begin
                  c_q <= '0;
                  h_q <= '0;
               end
               if (bus.in_valid && in_ready_q) begin
                  x_q        <= bus.x_in;
                  in_ready_q <= 1'b0;
                  state_q    <= G0;
               end
            end
            G0, G2, G4, G6: begin
               acc_q   <= acc_load_d;
               state_q <= state_t'(state_q + 4'd1);
            end
            G1, G3, G5, G7: begin
               acc_q     <= acc_sum_d;
               gate_q[k] <= act_y;
               ovf_q     <= ovf_q | sat_flag;
               state_q   <= state_t'(state_q + 4'd1);
            end
            C0: begin
               acc_q   <= ACC_W'(prod);
               state_q <= C1;
            end
            C1: begin
               acc_q   <= acc_sum_d;
               cnew_q  <= sat_v;
               ovf_q   <= ovf_q | sat_flag;
               state_q <= H0;
            end
            H0: begin
               c_q         <= cnew_q;
               h_q         <= sat_v;
               c_out_q     <= cnew_q;
               h_out_q     <= sat_v;
               ovf_q       <= ovf_q | sat_flag;
               out_valid_q <= 1'b1;
               state_q     <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.h_out     = h_out_q;
   assign bus.c_out     = c_out_q;
   assign bus.ovf       = ovf_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_lstm_cell_seq.sv
// Directed bench for lstm_cell_seq (DW=8, FRAC=4) with hand-computed {ovf, h, c} results.
// Expected results are queued at issue; a negedge monitor pops one per output handshake.
module tb_lstm_cell_seq;
   import lstm_pkg::*;

   localparam int DW = 8;
   localparam int W  = 2*DW + 1;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   logic [W-1:0] exp_q[$];

   lstm_cell_seq_if #(.DW(DW)) bus ();

   lstm_cell_seq #(.DW(DW), .FRAC(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
      end
   endtask

   function automatic logic [W-1:0] pk(input logic ovf, input int h, input int c);
      logic [DW-1:0] hb, cb;
      hb = DW'(h);
      cb = DW'(c);
      return {ovf, hb, cb};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_w(input logic [31:0] wx, input logic [31:0] wh, input logic [31:0] b);
      bus.w_x  = wx;
      bus.w_h  = wh;
      bus.bias = b;
   endtask

   task automatic send(input logic [7:0] x, input logic clr);
      int n;
      @(posedge clk); #1;
      bus.in_valid    = 1'b1;
      bus.x_in        = x;
      bus.clear_state = clr;
      n = 0;
      while (!bus.in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("accept_ready", {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk); #1;
      bus.in_valid    = 1'b0;
      bus.clear_state = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(posedge clk); #1;
      while (!bus.in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("idle_ready", {31'd0, bus.in_ready}, 32'd1);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin : monitor
      logic [W-1:0] e;
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: h_out=%0h c_out=%0h with no expected result", bus.h_out, bus.c_out);
         end else begin
            e = exp_q.pop_front();
            chk("h_out", {24'd0, bus.h_out}, {24'd0, e[15:8]});
            chk("c_out", {24'd0, bus.c_out}, {24'd0, e[7:0]});
            chk("ovf",   {31'd0, bus.ovf},   {31'd0, e[16]});
         end
      end
   end

   // ---------------- stimulus ----------------
   localparam logic [31:0] B_G16 = 32'h0010_0000;

   initial begin
      int n;
      checks = 0;
      errors = 0;
      rst_n           = 1'b0;
      bus.in_valid    = 1'b0;
      bus.x_in        = '0;
      bus.clear_state = 1'b0;
      bus.out_ready   = 1'b1;
      set_w(32'd0, 32'd0, 32'd0);

      #12;
      chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_h_out",     {24'd0, bus.h_out},     32'd0);
      chk("rst_c_out",     {24'd0, bus.c_out},     32'd0);
      chk("rst_ovf",       {31'd0, bus.ovf},       32'd0);
      chk("rst_state",     {28'd0, bus.dbg_state}, {28'd0, IDLE});
      @(negedge clk);
      rst_n = 1'b1;

      // 1: all-zero weights, latency exactly 11 cycles
      exp_q.push_back(pk(1'b0, 0, 0));
      send(8'd5, 1'b0);
      repeat (10) @(posedge clk);
      #1 chk("lat_edge10_low", {31'd0, bus.out_valid}, 32'd0);
      @(posedge clk);
      #1 chk("lat_edge11_high", {31'd0, bus.out_valid}, 32'd1);
      wait_idle();

      // 2: bias_g = 1.0, two back-to-back steps
      set_w(32'd0, 32'd0, B_G16);
      exp_q.push_back(pk(1'b0, 4, 8));
      send(8'd0, 1'b0);
      exp_q.push_back(pk(1'b0, 6, 12));
      send(8'd0, 1'b0);
      wait_idle();

      // 3: clear with accept restarts from zero; clear mid-step is ignored
      exp_q.push_back(pk(1'b0, 4, 8));
      send(8'd0, 1'b1);
      exp_q.push_back(pk(1'b0, 6, 12));
      send(8'd0, 1'b0);
      exp_q.push_back(pk(1'b0, 4, 8));
      send(8'd0, 1'b1);
      exp_q.push_back(pk(1'b0, 6, 12));
      send(8'd0, 1'b0);
      repeat (3) @(posedge clk);
      #1 bus.clear_state = 1'b1;
      @(posedge clk);
      #1 bus.clear_state = 1'b0;
      wait_idle();

      // negative weights: floor shift and htanh clamp on c
      set_w(32'h20E8_E010, 32'd0, 32'd0);
      exp_q.push_back(pk(1'b0, -12, -12));
      send(8'd16, 1'b1);
      wait_idle();
      set_w(32'h20E8_E010, 32'h0000_E000, 32'd0);
      exp_q.push_back(pk(1'b0, -16, -17));
      send(8'd16, 1'b0);
      wait_idle();

      // 4: saturating input gate, sticky ovf
      set_w(32'h0000_007F, 32'd0, 32'd0);
      exp_q.push_back(pk(1'b1, 0, 0));
      send(8'd127, 1'b1);
      wait_idle();
      set_w(32'd0, 32'd0, B_G16);
      exp_q.push_back(pk(1'b1, 4, 8));
      send(8'd0, 1'b0);
      exp_q.push_back(pk(1'b1, 6, 12));
      send(8'd0, 1'b0);
      wait_idle();

      // 5: downstream back-pressure for 20 cycles
      bus.out_ready = 1'b0;
      exp_q.push_back(pk(1'b1, 7, 14));
      send(8'd0, 1'b0);
      n = 0;
      while (!bus.out_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         chk("hold_h_out",    {24'd0, bus.h_out},    32'd7);
         chk("hold_c_out",    {24'd0, bus.c_out},    32'd14);
         chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("rel_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rel_in_ready",  {31'd0, bus.in_ready},  32'd1);
      chk("rel_state",     {28'd0, bus.dbg_state}, {28'd0, IDLE});

      // 6: reset during C0 aborts the step
      send(8'd0, 1'b0);
      repeat (8) @(posedge clk);
      #1 chk("pre_rst_state", {28'd0, bus.dbg_state}, {28'd0, C0});
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("mid_rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
      chk("mid_rst_h_out",     {24'd0, bus.h_out},     32'd0);
      chk("mid_rst_c_out",     {24'd0, bus.c_out},     32'd0);
      chk("mid_rst_ovf",       {31'd0, bus.ovf},       32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(pk(1'b0, 4, 8));
      send(8'd0, 1'b0);
      wait_idle();

      repeat (3) @(posedge clk);
      chk("exp_q_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lstm_cell_seq.md
Name: lstm_cell_seq

Overview:
- Parametrised, time-multiplexed fixed-point LSTM cell. Owns the recurrent state registers (c, h) across time steps.
- Computes one LSTM step per accepted input sample. One shared multiplier is sequenced by an FSM, with valid/ready handshakes on input and output.
- Sits between the feature front end (streams x samples) and the classifier/recurrent layer stack. Replaces the single-cycle combinational cell.

Parameters:
- DW, 8, signed data/weight width (two's complement, Q format)
- FRAC, 4, fractional bits; 1.0 = 1<<FRAC
- ACC_W, 2*DW+4, accumulator width for gate pre-activations

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  cell can accept a sample
- x_in  in  DW  input sample
- w_x  in  4*DW  input weights, packed gate order i,f,g,o (i at LSBs)
- w_h  in  4*DW  recurrent weights, same packing
- bias  in  4*DW  gate biases, same packing
- clear_state  in  1  zero c and h
- out_valid  out  1  h_out/c_out valid
- out_ready  in  1  downstream accepts result
- h_out  out  DW  new hidden state
- c_out  out  DW  new cell state
- ovf  out  1  sticky saturation flag

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; c, h, gate regs, accumulator = 0; in_ready=0 during reset; out_valid=0; h_out=0; c_out=0; ovf=0. Reset mid-step aborts the step; no partial update is retained.
- IDLE: in_ready=1. Accept when in_valid&&in_ready. x_in is latched at accept.
  - w_x, w_h and bias are quasi-static: they must be held stable from accept until out_valid. They are not latched.
- clear_state: honoured only in IDLE. Zeros c and h on that edge. If in_valid is also high on the same edge, the sample is accepted and the step uses the zeroed state. Ignored outside IDLE.
- Compute sequence, one state per cycle, after accept edge N:
  - G0..G7: for gate k=0..3, two states each.
    - First state: acc = bias_k<<FRAC + x*w_x_k.
    - Second state: acc += h*w_h_k. Then pre = sat_DW(acc>>>FRAC), and gate_k = act(pre).
  - C0: acc = f*c.
  - C1: acc += i*g; c_new = sat_DW(acc>>>FRAC).
  - H0: h_new = sat_DW((o*htanh(c_new))>>>FRAC). c and h registers updated.
  - DONE: out_valid=1 from the edge N+11 (latency 11 cycles, accept to out_valid).
- DONE: h_out and c_out are held stable while out_valid. On out_valid&&out_ready, go to IDLE. out_valid falls on the next edge. No input is accepted in the same cycle.
- Activations (combinational):
  - i, f, o: hsig(p) = clamp((p>>>2) + (1<<(FRAC-1)), 0, 1<<FRAC).
  - g: htanh(p) = clamp(p, -(1<<FRAC), 1<<FRAC).
- Arithmetic:
  - Products are full 2*DW signed.
  - Shifts are arithmetic (truncate toward -inf).
  - sat_DW clamps to [-(2^(DW-1)), 2^(DW-1)-1].
- ovf: set whenever any sat_DW clamps. Sticky until reset.
- in_ready=0 in every state except IDLE.

Decomposition:
- Shared package lstm_pkg:
  - FSM state enum (IDLE, G0..G7, C0, C1, H0, DONE)
  - gate index constants GATE_I=0, GATE_F=1, GATE_G=2, GATE_O=3
  - sat/hsig/htanh functions, parametrised by DW/FRAC
- One sub-module: lstm_act, a combinational hsig/htanh selected by a mode bit, instantiated once and shared across gates.
- Multiplier and accumulator stay inline.

Test Plan (DW=8, FRAC=4):
1. All weights/biases 0, x=5 -> i=f=o=8, g=0. Expect out_valid exactly 11 cycles after accept, h_out=0, c_out=0, ovf=0.
2. bias_g=16, others 0, x=0, two back-to-back steps:
   - step 1 -> c_out=8, h_out=4
   - step 2 -> c_out=12, h_out=6
3. Repeat test 2, then clear_state with in_valid in IDLE -> step result c_out=8, h_out=4 (state zeroed first). clear_state pulsed mid-step has no effect.
4. x=127, w_x_i=127 -> pre-activation saturates, ovf=1 and stays 1 through later clean steps. No X/wrap on h_out.
5. Hold out_ready=0 for 20 cycles after out_valid -> h_out/c_out stable, in_ready=0, new in_valid ignored. Release -> IDLE next cycle.
6. Assert rst_n=0 at state C0 -> all outputs 0 immediately. After release, a step from test 2 gives c_out=8 (state not corrupted).
